c_drain: RTL

C_DRAIN -- requirements
Module: c_drain

---
 rtl/c_drain_pkg.sv | 17 +
 rtl/c_drain.sv | 100 ++++++++++
 2 files changed

// File: rtl/c_drain_pkg.sv
// Shared TPU package: array geometry and C-drain FSM state encoding.
// Used by the array, buffer and drain blocks.
package c_drain_pkg;

  localparam int N_LANES = 4;
  localparam int WORD_W  = 32;
  localparam int ROW_W   = N_LANES * WORD_W;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    SEND,
    DONE
  } drain_state_e;

endpackage

// File: rtl/c_drain.sv
// C drain: reads C rows from the buffer and streams them out word by word
// (lane 0 = MSBs first) over a valid/ready port. Ports: clk, rst_n,
// start/rows request, busy/done status, C_index/C_data_out buffer read,
// out_valid/out_ready/out_data/out_last result stream.
module c_drain
  import c_drain_pkg::*;
#(
  parameter int N_LANES = c_drain_pkg::N_LANES,
  parameter int WORD_W  = c_drain_pkg::WORD_W,
  parameter int ROW_W   = c_drain_pkg::ROW_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rows,
  output logic              busy,
  output logic              done,
  output logic [15:0]       C_index,
  input  logic [ROW_W-1:0]  C_data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last
);

  localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [LW-1:0] L_MAX = LW'(N_LANES - 1);

  drain_state_e     state_q;
  drain_state_e     state_d;
  logic [7:0]       rows_q;
  logic [7:0]       r_q;
  logic [LW-1:0]    l_q;
  logic [ROW_W-1:0] row_q;
  logic             xfer;
  logic             lane_end;
  logic             more;

  assign xfer     = (state_q == SEND) && out_ready;
  assign lane_end = (l_q == L_MAX);
  // widened so r+1 cannot wrap
  assign more     = ({1'b0, r_q} + 9'd1) < {1'b0, rows_q};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = (rows != 8'd0) ? READ : DONE;
      end
      READ: state_d = LOAD;
      LOAD: state_d = SEND;
      SEND: begin
        if (xfer && lane_end) state_d = more ? READ : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rows_q  <= '0;
      r_q     <= '0;
      l_q     <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start && rows != 8'd0) begin
        rows_q <= rows;
        r_q    <= '0;
      end
      if (state_q == LOAD) begin
        row_q <= C_data_out;
        l_q   <= '0;
      end
      if (xfer) begin
        l_q <= l_q + 1'b1;
        if (lane_end) r_q <= r_q + 8'd1;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_valid = (state_q == SEND);
  assign C_index   = {8'd0, r_q};
  assign out_last  = out_valid && lane_end &&
                     (r_q == rows_q - 8'd1);

  // lane mux; held at zero outside SEND
  always_comb begin
    out_data = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (out_valid && l_q == LW'(i))
        out_data = row_q[ROW_W-1-WORD_W*i -: WORD_W];
    end
  end

endmodule
